// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one multiplier bit per clock.
// Product and WE are registered and feed a downstream result register directly.
`default_nettype none

module seq_multiplier #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           Reset,
   input  logic           Start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic [2*N-1:0] Product,
   output logic           WE,
   output logic           Busy
);

   localparam int            CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [2*N-1:0]  mcand_q;
   logic [N-1:0]    mplier_q;
   logic [2*N-1:0]  acc_q;
   logic [2*N-1:0]  acc_d;
   logic [CW-1:0]   cnt_q;
   logic [2*N-1:0]  product_q;
   logic            we_q;
   logic            busy_q;

   always_comb begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            // DONE also accepts Start so back-to-back operations run every N+1 cycles.
            IDLE, DONE: begin
               if (Start) begin
                  mcand_q  <= {{N{1'b0}}, A};
                  mplier_q <= B;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  product_q <= acc_d;
                  we_q      <= 1'b1;
                  state_q   <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Product = product_q;
   assign WE      = we_q;
   assign Busy    = busy_q;

endmodule

`default_nettype wire
